// File: rtl/bitonic_sort_feeder_if.sv
// Stream, sorter and result bundle for bitonic_sort_feeder.
// slave is the feeder side; master is its environment.
interface bitonic_sort_feeder_if #(
  parameter int N           = 16,
  parameter int log_N       = 4,
  parameter int INPUT_WIDTH = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [INPUT_WIDTH-1:0]     in_data;
  logic                       in_last;
  logic [0:N*INPUT_WIDTH-1]   sort_in;
  logic [0:N*INPUT_WIDTH-1]   sort_out;
  logic                       out_valid;
  logic [0:N*INPUT_WIDTH-1]   out_data;
  logic [log_N:0]             out_count;

  modport slave (
    input  in_valid, in_data, in_last, sort_out,
    output in_ready, sort_in, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_last, sort_out,
    input  in_ready, sort_in, out_valid, out_data, out_count
  );
endinterface

// File: rtl/bitonic_sort_feeder.sv
// Frame collector and launcher for the bitonic sorter.
// Pads short frames and tags each launch through the sorter latency.
module bitonic_sort_feeder #(
  parameter int N            = 16,
  parameter int log_N        = 4,
  parameter int INPUT_WIDTH  = 4,
  parameter bit polarity     = 1'b0,
  parameter int SORT_LATENCY = 10
) (
  input logic                  clk,
  input logic                  reset_n,
  bitonic_sort_feeder_if.slave bus
);
  localparam int W = INPUT_WIDTH;
  localparam logic [W-1:0] PAD =
    (polarity == 1'b0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [log_N-1:0] LAST = log_N'(N - 1);

  typedef struct packed {
    logic           vld;
    logic [log_N:0] cnt;
  } tag_t;

  logic [log_N-1:0] idx;
  logic [W-1:0]     fill [N];
  logic [0:N*W-1]   frame;
  logic [0:N*W-1]   launch;
  tag_t             tags [SORT_LATENCY+1];
  logic             ready;
  logic             accept;
  logic             done;
  logic [log_N:0]   count;
  logic             valid_q;
  logic [0:N*W-1]   data_q;
  logic [log_N:0]   count_q;

  assign accept = bus.in_valid && ready;
  assign done   = accept && (bus.in_last || idx == LAST);
  assign count  = {1'b0, idx} + (log_N+1)'(1);

  assign bus.in_ready  = ready;
  assign bus.sort_in   = launch;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;

  // Fill buffer merged with the element accepted this cycle.
  always_comb begin
    frame = '0;
    for (int k = 0; k < N; k++) begin
      frame[k*W +: W] = fill[k];
      if (accept && idx == log_N'(k))
        frame[k*W +: W] = bus.in_data;
    end
  end

  // Collect elements and launch the frame on completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready  <= 1'b0;
      idx    <= '0;
      launch <= {N{PAD}};
      for (int k = 0; k < N; k++)
        fill[k] <= PAD;
    end else begin
      ready <= 1'b1;
      if (done) begin
        launch <= frame;
        idx    <= '0;
        for (int k = 0; k < N; k++)
          fill[k] <= PAD;
      end else if (accept) begin
        fill[idx] <= bus.in_data;
        idx       <= idx + 1'b1;
      end
    end
  end

  // Tag shift register shadowing the sorter pipeline.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k <= SORT_LATENCY; k++)
        tags[k] <= '0;
    end else begin
      tags[0] <= '{vld: done, cnt: done ? count : '0};
      for (int k = 1; k <= SORT_LATENCY; k++)
        tags[k] <= tags[k-1];
    end
  end

  // Capture the sorted frame when its tag emerges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= tags[SORT_LATENCY].vld;
      if (tags[SORT_LATENCY].vld) begin
        data_q  <= bus.sort_out;
        count_q <= tags[SORT_LATENCY].cnt;
      end
    end
  end
endmodule

// File: tb/tb_bitonic_sort_feeder.sv
// Bench for bitonic_sort_feeder: both polarities side by side,
// behavioural sorter and frame model, directed then random stimulus.
module tb_bitonic_sort_feeder;
  localparam int N    = 4;
  localparam int LOGN = 2;
  localparam int W    = 4;
  localparam int L    = 3;
  localparam int FW   = N * W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_last = 1'b0;

  always #5 clk = ~clk;

  bitonic_sort_feeder_if #(.N(N), .log_N(LOGN), .INPUT_WIDTH(W)) bus0 ();
  bitonic_sort_feeder_if #(.N(N), .log_N(LOGN), .INPUT_WIDTH(W)) bus1 ();

  bitonic_sort_feeder #(
    .N(N), .log_N(LOGN), .INPUT_WIDTH(W),
    .polarity(1'b0), .SORT_LATENCY(L)
  ) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  bitonic_sort_feeder #(
    .N(N), .log_N(LOGN), .INPUT_WIDTH(W),
    .polarity(1'b1), .SORT_LATENCY(L)
  ) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus0.in_last  = in_last;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus1.in_last  = in_last;

  function automatic logic [0:FW-1] sortf(input logic [0:FW-1] f,
                                          input bit desc);
    int v [N];
    int t;
    logic [0:FW-1] r;
    for (int k = 0; k < N; k++) v[k] = int'(f[k*W +: W]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(v[k]);
    return r;
  endfunction

  // Behavioural sorter with L cycles of latency.
  logic [0:FW-1] srt0 [L];
  logic [0:FW-1] srt1 [L];
  initial for (int k = 0; k < L; k++) begin srt0[k] = '0; srt1[k] = '0; end
  always @(posedge clk) begin
    srt0[0] <= sortf(bus0.sort_in, 1'b0);
    srt1[0] <= sortf(bus1.sort_in, 1'b1);
    for (int k = 1; k < L; k++) begin
      srt0[k] <= srt0[k-1];
      srt1[k] <= srt1[k-1];
    end
  end
  assign bus0.sort_out = srt0[L-1];
  assign bus1.sort_out = srt1[L-1];

  // Frame-level reference model.
  int cyc = 0;
  bit m_ready = 1'b0;
  bit m_valid = 1'b0;
  logic [W-1:0] cur [$];
  int due_q [$];
  logic [0:FW-1] d0_q [$];
  logic [0:FW-1] d1_q [$];
  int cnt_q [$];
  logic [0:FW-1] m_sin0, m_sin1, m_out0, m_out1;
  int m_cnt = 0;

  function automatic logic [0:FW-1] frame_of(input bit pol);
    logic [0:FW-1] r;
    for (int k = 0; k < N; k++)
      r[k*W +: W] = (k < cur.size()) ? cur[k] : (pol ? 4'h0 : 4'hF);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_valid = 1'b0;
    if (!reset_n) begin
      m_ready = 1'b0;
      cur.delete(); due_q.delete(); d0_q.delete();
      d1_q.delete(); cnt_q.delete();
      m_sin0 = 16'hFFFF; m_sin1 = 16'h0000;
      m_out0 = '0; m_out1 = '0; m_cnt = 0;
    end else begin
      if (in_valid && m_ready) begin
        cur.push_back(in_data);
        if (in_last || cur.size() == N) begin
          m_sin0 = frame_of(1'b0);
          m_sin1 = frame_of(1'b1);
          due_q.push_back(cyc + L + 1);
          d0_q.push_back(sortf(m_sin0, 1'b0));
          d1_q.push_back(sortf(m_sin1, 1'b1));
          cnt_q.push_back(cur.size());
          cur.delete();
        end
      end
      m_ready = 1'b1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        m_valid = 1'b1;
        m_out0 = d0_q.pop_front();
        m_out1 = d1_q.pop_front();
        m_cnt  = cnt_q.pop_front();
        void'(due_q.pop_front());
      end
    end
  end

  // Hand-computed expectations armed by the stimulus.
  logic [15:0] lit_d0 [16];
  logic [15:0] lit_d1 [16];
  int lit_c [16];
  int lit_n = 0;
  int lit_k = 0;
  int lit_wait = 0;

  int vec = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Compare both DUTs against the model every cycle.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("in_ready0", 32'(bus0.in_ready), 32'(m_ready));
      chk("in_ready1", 32'(bus1.in_ready), 32'(m_ready));
      chk("sort_in0", 32'(bus0.sort_in), 32'(m_sin0));
      chk("sort_in1", 32'(bus1.sort_in), 32'(m_sin1));
      chk("out_valid0", 32'(bus0.out_valid), 32'(m_valid));
      chk("out_valid1", 32'(bus1.out_valid), 32'(m_valid));
      chk("out_data0", 32'(bus0.out_data), 32'(m_out0));
      chk("out_data1", 32'(bus1.out_data), 32'(m_out1));
      chk("out_count0", 32'(bus0.out_count), 32'(m_cnt));
      chk("out_count1", 32'(bus1.out_count), 32'(m_cnt));
      if (lit_k < lit_n) begin
        if (bus0.out_valid === 1'b1) begin
          chk("lit_data0", 32'(bus0.out_data), 32'(lit_d0[lit_k]));
          chk("lit_data1", 32'(bus1.out_data), 32'(lit_d1[lit_k]));
          chk("lit_count", 32'(bus0.out_count), 32'(lit_c[lit_k]));
          chk("lit_model0", 32'(m_out0), 32'(lit_d0[lit_k]));
          chk("lit_model1", 32'(m_out1), 32'(lit_d1[lit_k]));
          lit_k++;
          lit_wait = 0;
        end else if (++lit_wait > 40) begin
          vec++;
          errs++;
          $display("FAIL lit_timeout cycle %0d: got no out_valid want %h",
                   cyc, lit_d0[lit_k]);
          lit_k++;
          lit_wait = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic arm(input logic [15:0] a, input logic [15:0] b,
                     input int c);
    lit_d0[lit_n] = a;
    lit_d1[lit_n] = b;
    lit_c[lit_n]  = c;
    lit_n++;
  endtask

  task automatic drain();
    wait (lit_k == lit_n);
    step();
  endtask

  initial begin
    in_valid = 1'b1;
    in_data  = 4'hA;
    repeat (3) step();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    step();

    arm(16'h0123, 16'h3210, 4);
    send(4'd3, 1'b0); send(4'd1, 1'b0);
    send(4'd2, 1'b0); send(4'd0, 1'b1);
    drain();

    arm(16'h25FF, 16'h5200, 2);
    send(4'd5, 1'b0); send(4'd2, 1'b1);
    drain();

    arm(16'h6789, 16'h9876, 4);
    arm(16'h4FFF, 16'h4000, 1);
    send(4'd9, 1'b0); send(4'd8, 1'b0);
    gap(2);
    send(4'd7, 1'b0); send(4'd6, 1'b0);
    send(4'd4, 1'b1);
    drain();

    arm(16'h17FF, 16'h7100, 2);
    send(4'd1, 1'b0); send(4'd7, 1'b1);
    drain();

    send(4'd5, 1'b0); send(4'd6, 1'b0);
    send(4'd7, 1'b0); send(4'd8, 1'b0);
    send(4'd1, 1'b0); send(4'd2, 1'b0);
    gap(1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    gap(8);
    arm(16'h01FF, 16'h1000, 2);
    send(4'd1, 1'b0); send(4'd0, 1'b1);
    drain();

    for (int i = 0; i < 3000; i++) begin
      reset_n  = ($urandom_range(0, 199) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = W'($urandom);
      in_last  = ($urandom_range(0, 3) == 0);
      step();
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (12) step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
